upc_flip: RTL and testbench
===========================

UPC_FLIP -- requirements
Module: upc_flip

Interface
REQ-001 SHALL have parameter R, default 127, meaning circulant block length in bits.
REQ-002 SHALL have parameter W, default 5, meaning number of set positions in one sparse parity-check block.
REQ-003 SHALL have parameter POS_W, default 8, meaning bit width of one position index.
REQ-004 SHALL have parameter CNT_W, default 3, meaning counter width; SHALL satisfy 2^CNT_W > W.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  single-cycle request to begin one flip round.
REQ-008 s  input  R  syndrome vector from the syndrome stage.
REQ-009 h_pos_flat  input  W*POS_W  positions of block h; entry k at bits [k*POS_W +: POS_W].
REQ-010 th  input  CNT_W  flip threshold.
REQ-011 flip  output  R  flip mask; bit j set when upc[j] >= th.
REQ-012 upc_max  output  CNT_W  largest upc value seen in the round.
REQ-013 busy  output  1  high while a round is in progress.
REQ-014 done  output  1  one-cycle pulse when flip and upc_max are valid.

Function
REQ-015 upc[j] SHALL equal sum over k=0..W-1 of s[(j + pos_k) mod R], for j=0..R-1; this is the transpose of the syndrome convention s[i] = XOR_k c[(i - pos_k) mod R].
REQ-016 Positions SHALL be in 0..R-1; for out-of-range positions flip content is unspecified, but the FSM SHALL still terminate with the normal latency.
REQ-017 Index arithmetic SHALL use a modular add (j + pos, minus R if >= R), not a wide modulo.
REQ-018 FSM states: IDLE, SCAN, FIN.
REQ-019 IDLE: on start, SHALL latch s, h_pos_flat and th; clear flip, upc_max and j; go to SCAN.
REQ-020 SCAN: each cycle SHALL evaluate exactly one index j, write flip[j] <= (upc[j] >= th), update upc_max, and increment j.
REQ-021 SCAN SHALL move to FIN after j = R-1 is processed.
REQ-022 FIN: SHALL assert done for one cycle, then return to IDLE.
REQ-023 If start is accepted at edge 0, done SHALL be high in the cycle after edge R+1, giving a fixed latency of R+1 cycles.
REQ-024 busy SHALL be high in SCAN and FIN.
REQ-025 start SHALL be ignored while busy; latched operands SHALL NOT change mid-round.
REQ-026 start in the same cycle as FIN SHALL be ignored; a new round may begin in the cycle after done.
REQ-027 flip and upc_max SHALL hold their values after done until the next accepted start.
REQ-028 th = 0 SHALL set every flip bit.
REQ-029 th > W SHALL clear every flip bit.
REQ-030 Evaluation of j SHALL wrap correctly at j = R-1 for every pos_k.

Reset
REQ-031 rst SHALL force IDLE and set flip=0, upc_max=0, busy=0, done=0, j=0.
REQ-032 rst mid-round SHALL abort the round with no done pulse; latched operand registers need no reset.

Structure
REQ-033 R, W, POS_W and CNT_W defaults SHALL live in a shared package (kem_pkg) also used by the syndrome stage.
REQ-034 The W-input bit counter SHALL be a combinational sub-module named upc_popcount (W inputs, CNT_W-bit sum).
REQ-035 Per-index bit selection and the comparator SHALL stay in upc_flip.

Verification
REQ-036 pos={0,1,2,3,4}, s=0, th=1 -> flip=0, upc_max=0, done exactly 128 cycles after start.
REQ-037 pos={0,1,2,3,4}, s=bit0 only, th=1 -> flip bits {0,123,124,125,126} set, all others clear, upc_max=1 (wrap check).
REQ-038 s=all ones, th=5 -> flip all ones, upc_max=5; same s with th=6 -> flip=0.
REQ-039 Random s and positions, th=3 -> flip matches a software model of REQ-015; a second start pulse at cycle 40 is ignored with no change in result or latency.
REQ-040 rst asserted at cycle 50 of a round -> no done pulse, flip=0, busy=0 next cycle; a new start afterwards completes normally.

Source files
------------

// File: rtl/kem_pkg.sv
// Shared QC-MDPC code dimensions and the flip-stage FSM encoding.
// Used by the syndrome stage and the unsatisfied-parity-check flip stage.
package kem_pkg;

    localparam int KEM_R     = 127;  // circulant block length in bits
    localparam int KEM_W     = 5;    // set positions per sparse block
    localparam int KEM_POS_W = 8;    // width of one position index
    localparam int KEM_CNT_W = 3;    // counter width, 2**KEM_CNT_W > KEM_W

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } upc_state_t;

endpackage

// File: rtl/upc_popcount.sv
// Purpose: count set bits across the W selected syndrome bits.
// Latency: combinational.  Backpressure: none, pure function of its input.
module upc_popcount #(
    parameter int W     = 5,
    parameter int CNT_W = 3
) (
    input  logic [W-1:0]     bits,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int k = 0; k < W; k++) begin
            cnt = cnt + CNT_W'(bits[k]);
        end
    end

endmodule

// File: rtl/upc_flip.sv
// Purpose: one bit-flip round; flip[j] = (sum_k s[(j+pos_k) mod R] >= th).
// Latency: done high R+1 cycles after start.  Backpressure: start ignored while busy.
module upc_flip
    import kem_pkg::*;
#(
    parameter int R     = KEM_R,
    parameter int W     = KEM_W,
    parameter int POS_W = KEM_POS_W,
    parameter int CNT_W = KEM_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [R-1:0]         s,
    input  logic [W*POS_W-1:0]   h_pos_flat,
    input  logic [CNT_W-1:0]     th,
    output logic [R-1:0]         flip,
    output logic [CNT_W-1:0]     upc_max,
    output logic                 busy,
    output logic                 done
);

    localparam int JW = $clog2(R + 1);   // j must be able to reach R
    localparam int SW = $clog2(R);       // index into an R-bit vector
    localparam int IW = POS_W + 1;       // j + pos without overflow
    localparam logic [IW-1:0] R_I  = IW'(R);
    localparam logic [JW-1:0] R_J  = JW'(R);
    localparam logic [SW-1:0] LAST = SW'(R - 1);

    upc_state_t state, state_nxt;

    logic [R-1:0]       s_q;
    logic [W*POS_W-1:0] pos_q;
    logic [CNT_W-1:0]   th_q;

    logic [JW-1:0]      j;
    logic [W-1:0]       sel;
    logic [CNT_W-1:0]   cnt;

    logic               pipe_vld;
    logic [SW-1:0]      idx_q;
    logic [CNT_W-1:0]   upc_q;

    logic               accept;
    logic               issue;
    logic               last_wr;

    assign accept  = (state == ST_IDLE) && start;
    assign issue   = (state == ST_SCAN) && (j < R_J);
    assign last_wr = pipe_vld && (idx_q == LAST);

    // Single conditional subtract keeps the index in range for valid positions;
    // anything still out of range reads as zero so the scan length never changes.
    for (genvar k = 0; k < W; k++) begin : g_sel
        logic [IW-1:0] raw;
        logic [IW-1:0] wrapped;
        assign raw     = IW'(j) + IW'(pos_q[k*POS_W +: POS_W]);
        assign wrapped = (raw >= R_I) ? (raw - R_I) : raw;
        assign sel[k]  = (wrapped < R_I) ? s_q[wrapped[SW-1:0]] : 1'b0;
    end

    upc_popcount #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_popcount (
        .bits (sel),
        .cnt  (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (last_wr) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operands are only ever captured on an accepted start, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s_q   <= s;
            pos_q <= h_pos_flat;
            th_q  <= th;
        end
    end

    // Two-stage scan: stage one counts index j, stage two commits flip/upc_max.
    always_ff @(posedge clk) begin
        if (rst) begin
            j        <= '0;
            pipe_vld <= 1'b0;
            idx_q    <= '0;
            upc_q    <= '0;
            flip     <= '0;
            upc_max  <= '0;
        end else if (accept) begin
            j        <= '0;
            pipe_vld <= 1'b0;
            flip     <= '0;
            upc_max  <= '0;
        end else begin
            pipe_vld <= issue;
            if (issue) begin
                upc_q <= cnt;
                idx_q <= j[SW-1:0];
                j     <= j + JW'(1);
            end
            if (pipe_vld) begin
                flip[idx_q] <= (upc_q >= th_q);
                if (upc_q > upc_max) begin
                    upc_max <= upc_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_upc_flip.sv
// Directed bench for upc_flip: latency, wrap, thresholds, ignored start, abort.
module tb_upc_flip;
    import kem_pkg::*;

    localparam int R     = KEM_R;
    localparam int W     = KEM_W;
    localparam int POS_W = KEM_POS_W;
    localparam int CNT_W = KEM_CNT_W;

    logic               clk;
    logic               rst;
    logic               start;
    logic [R-1:0]       s;
    logic [W*POS_W-1:0] h_pos_flat;
    logic [CNT_W-1:0]   th;
    logic [R-1:0]       flip;
    logic [CNT_W-1:0]   upc_max;
    logic               busy;
    logic               done;

    int n_cmp = 0;
    int n_bad = 0;

    upc_flip #(.R(R), .W(W), .POS_W(POS_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s          (s),
        .h_pos_flat (h_pos_flat),
        .th         (th),
        .flip       (flip),
        .upc_max    (upc_max),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W*POS_W-1:0] pack_pos(input int p0, input int p1, input int p2,
                                                    input int p3, input int p4);
        logic [W*POS_W-1:0] v;
        v = '0;
        v[0*POS_W +: POS_W] = POS_W'(p0);
        v[1*POS_W +: POS_W] = POS_W'(p1);
        v[2*POS_W +: POS_W] = POS_W'(p2);
        v[3*POS_W +: POS_W] = POS_W'(p3);
        v[4*POS_W +: POS_W] = POS_W'(p4);
        return v;
    endfunction

    // Reference: upc[j] = sum_k s[(j + pos_k) % R], computed with a plain modulo.
    task automatic model(input logic [R-1:0] sv, input logic [W*POS_W-1:0] pv,
                         input logic [CNT_W-1:0] thv,
                         output logic [R-1:0] fexp, output logic [CNT_W-1:0] mexp);
        int u;
        int p;
        fexp = '0;
        mexp = '0;
        for (int jj = 0; jj < R; jj++) begin
            u = 0;
            for (int k = 0; k < W; k++) begin
                p = int'(pv[k*POS_W +: POS_W]);
                u += int'(sv[(jj + p) % R]);
            end
            if (u >= int'(thv)) fexp[jj] = 1'b1;
            if (u > int'(mexp)) mexp = CNT_W'(u);
        end
    endtask

    // Starts a round; optionally fires a stray start (with scrambled inputs) or a reset.
    task automatic run_round(input logic [R-1:0] sv, input logic [W*POS_W-1:0] pv,
                             input logic [CNT_W-1:0] thv, input int extra_at, input int rst_at,
                             output int lat, output bit seen);
        s = sv;
        h_pos_flat = pv;
        th = thv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        seen = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat = c;
                break;
            end
            if (c == rst_at + 1) begin
                chk("abort_busy", 128'(busy), 128'(0));
                chk("abort_flip", 128'(flip), 128'(0));
                chk("abort_max", 128'(upc_max), 128'(0));
                rst = 1'b0;
                break;
            end
            if (c == extra_at) begin
                start = 1'b1;
                s = ~sv;
                th = thv + CNT_W'(1);
                h_pos_flat = ~pv;
            end
            if (c == rst_at) rst = 1'b1;
        end
    endtask

    task automatic after_done(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 128'(done), 128'(0));
        chk({tag, "_busy_after"}, 128'(busy), 128'(0));
    endtask

    initial begin
        logic [R-1:0]       sv;
        logic [R-1:0]       fexp;
        logic [CNT_W-1:0]   mexp;
        logic [W*POS_W-1:0] pv;
        int                 lat;
        bit                 seen;

        rst = 1'b1;
        start = 1'b0;
        s = '0;
        h_pos_flat = '0;
        th = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flip", 128'(flip), 128'(0));
        chk("rst_max", 128'(upc_max), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // s = 0, th = 1: nothing flips, latency R+1
        pv = pack_pos(0, 1, 2, 3, 4);
        run_round('0, pv, 3'd1, -1, -1, lat, seen);
        chk("zero_lat", 128'(lat), 128'(128));
        chk("zero_flip", 128'(flip), 128'(0));
        chk("zero_max", 128'(upc_max), 128'(0));
        after_done("zero");

        // single bit 0 reaches j = 0,123..126 through the wrap
        sv = '0;
        sv[0] = 1'b1;
        fexp = '0;
        fexp[0] = 1'b1;
        fexp[126:123] = 4'hF;
        run_round(sv, pv, 3'd1, -1, -1, lat, seen);
        chk("wrap_lat", 128'(lat), 128'(128));
        chk("wrap_flip", 128'(flip), 128'(fexp));
        chk("wrap_max", 128'(upc_max), 128'(1));
        after_done("wrap");

        // all ones: every upc = 5
        sv = '1;
        run_round(sv, pv, 3'd5, -1, -1, lat, seen);
        chk("ones5_flip", 128'(flip), 128'({R{1'b1}}));
        chk("ones5_max", 128'(upc_max), 128'(5));
        after_done("ones5");
        repeat (4) @(posedge clk);
        #1;
        chk("hold_flip", 128'(flip), 128'({R{1'b1}}));
        chk("hold_max", 128'(upc_max), 128'(5));

        run_round(sv, pv, 3'd6, -1, -1, lat, seen);
        chk("ones6_flip", 128'(flip), 128'(0));
        chk("ones6_max", 128'(upc_max), 128'(5));
        after_done("ones6");

        // th = 0 sets every bit even with s = 0
        run_round('0, pv, 3'd0, -1, -1, lat, seen);
        chk("th0_flip", 128'(flip), 128'({R{1'b1}}));
        chk("th0_max", 128'(upc_max), 128'(0));
        after_done("th0");

        // random operands, stray start with scrambled inputs at cycle 40
        sv = {$urandom, $urandom, $urandom, $urandom};
        pv = pack_pos(int'($urandom_range(0, R-1)), int'($urandom_range(0, R-1)),
                      int'($urandom_range(0, R-1)), 126, int'($urandom_range(0, R-1)));
        model(sv, pv, 3'd3, fexp, mexp);
        run_round(sv, pv, 3'd3, 40, -1, lat, seen);
        chk("rand_lat", 128'(lat), 128'(128));
        chk("rand_flip", 128'(flip), 128'(fexp));
        chk("rand_max", 128'(upc_max), 128'(mexp));
        after_done("rand");

        // reset at cycle 50 aborts without done
        run_round(sv, pv, 3'd3, -1, 50, lat, seen);
        chk("abort_no_done", 128'(seen), 128'(0));
        @(posedge clk);
        #1;
        chk("abort_idle_done", 128'(done), 128'(0));

        sv = {$urandom, $urandom, $urandom, $urandom};
        pv = pack_pos(int'($urandom_range(0, R-1)), int'($urandom_range(0, R-1)),
                      int'($urandom_range(0, R-1)), int'($urandom_range(0, R-1)), 0);
        model(sv, pv, 3'd2, fexp, mexp);
        run_round(sv, pv, 3'd2, -1, -1, lat, seen);
        chk("post_lat", 128'(lat), 128'(128));
        chk("post_flip", 128'(flip), 128'(fexp));
        chk("post_max", 128'(upc_max), 128'(mexp));
        after_done("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
